// File: rtl/increase_counter.sv
// increase_counter: cascadable multi-digit up-counter (binary or BCD digits) with
// parallel load, dual count enables, combinational terminal count and sticky overflow.
module increase_counter #(
   parameter int DIGITS    = 2,
   parameter int DIGIT_MAX = 15
) (
   input  logic                  CP,
   input  logic                  CR,
   input  logic                  PE,
   input  logic                  CEP,
   input  logic                  CET,
   input  logic [4*DIGITS-1:0]   D,
   output logic [4*DIGITS-1:0]   Q,
   output logic                  TC,
   output logic                  OVF
);

   localparam int         W    = 4 * DIGITS;
   localparam logic [3:0] DMAX = 4'(DIGIT_MAX);

   logic [W-1:0]      cnt_q;
   logic [W-1:0]      cnt_d;
   logic [W-1:0]      inc;
   logic              ovf_q;
   logic              ovf_d;
   logic [DIGITS-1:0] term;
   logic              all_term;
   logic              step;
   logic [3:0]        dig;

   // Ripple the digit carry: a digit steps only when every lower digit is terminal.
   // Digits above DIGIT_MAX (only reachable by a load) count as terminal and wrap to 0.
   always_comb begin
      inc  = '0;
      term = '0;
      step = 1'b1;
      dig  = '0;
      for (int k = 0; k < DIGITS; k++) begin
         dig     = cnt_q[4*k +: 4];
         term[k] = (dig >= DMAX);
         if (step) begin
            inc[4*k +: 4] = term[k] ? 4'd0 : dig + 4'd1;
         end else begin
            inc[4*k +: 4] = dig;
         end
         step = step & term[k];
      end
   end

   assign all_term = &term;

   always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (!PE) begin
         cnt_d = D;
         ovf_d = 1'b0;
      end else if (CEP && CET) begin
         cnt_d = inc;
         if (all_term) begin
            ovf_d = 1'b1;
         end
      end
   end

   always_ff @(posedge CP or negedge CR) begin
      if (!CR) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   assign Q   = cnt_q;
   assign OVF = ovf_q;
   // Independent of CEP so the carry can ripple through a cascade of stages.
   assign TC  = CET & PE & all_term;

endmodule
